seq_detect_param: RTL and testbench

- Parametrised serial bit-pattern detector.
- Next generation of the fixed 5-bit "10001" Moore detector.
- Pattern length, runtime-loadable pattern with don't-care mask, overlap/non-overlap mode, input qualifier and saturating match counter.
- Sits on a serial input line; dout feeds LED/interrupt logic; match_cnt feeds display logic.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_detect_param_if.sv | 28 ++
 rtl/seq_detect_param_sat_counter.sv | 38 +++
 rtl/seq_detect_param.sv | 86 ++++++++
 tb/tb_seq_detect_param.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// The state is carried by the fill counter; FILL/ARMED name its two regions.
package seq_det_pkg;

   localparam logic [4:0] PAT_DEFAULT_5 = 5'b10001;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   function automatic int fill_w(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Detector control/data bundle; master drives the serial line and config, slave is the detector.
interface seq_detect_param_if #(
   parameter int PAT_LEN = 5,
   parameter int CNT_W   = 8
);
   logic               en;
   logic               din_valid;
   logic               din;
   logic               overlap;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_in;
   logic [PAT_LEN-1:0] mask_in;
   logic               cnt_clr;
   logic               dout;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;
   logic               armed;

   modport master (
      output en, din_valid, din, overlap, pat_load, pat_in, mask_in, cnt_clr,
      input  dout, match_cnt, cnt_sat, armed
   );

   modport slave (
      input  en, din_valid, din, overlap, pat_load, pat_in, mask_in, cnt_clr,
      output dout, match_cnt, cnt_sat, armed
   );
endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with registered saturation flag; clr_cnt with inc lands on 1.
// Latency 1; never wraps.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   input  logic         clr_cnt,
   output logic [W-1:0] q,
   output logic         sat
);
   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] q_n;
   logic         sat_n;

   always_comb begin
      q_n = q;
      if (clr_cnt) begin
         q_n = inc ? W'(1) : '0;
      end else if (inc && (q != MAX)) begin
         q_n = q + W'(1);
      end
      sat_n = (q_n == MAX);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q   <= '0;
         sat <= 1'b0;
      end else begin
         q   <= q_n;
         sat <= sat_n;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with loadable pattern/mask, overlap control and match counter.
// Moore output: dout rises the cycle after the matching bit is consumed; all outputs registered.
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_LEN     = 5,
   parameter logic [PAT_LEN-1:0] PAT_DEFAULT = PAT_LEN'(PAT_DEFAULT_5),
   parameter int               CNT_W       = 8
) (
   input logic                clk,
   input logic                clr,
   seq_detect_param_if.slave  bus
);
   localparam int             FW   = fill_w(PAT_LEN);
   localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

   logic [PAT_LEN-1:0] pattern_q, pattern_n;
   logic [PAT_LEN-1:0] mask_q, mask_n;
   logic [PAT_LEN-1:0] hist_q, hist_n, hist_sh;
   logic [FW-1:0]      fill_q, fill_n, fill_sh;
   state_t             state_q, state_n;
   logic               dout_q, dout_n;
   logic               hit;

   always_ff @(posedge clk) begin
      if (clr) begin
         pattern_q <= PAT_DEFAULT;
         mask_q    <= '0;
         hist_q    <= '0;
         fill_q    <= '0;
         state_q   <= FILL;
         dout_q    <= 1'b0;
      end else begin
         pattern_q <= pattern_n;
         mask_q    <= mask_n;
         hist_q    <= hist_n;
         fill_q    <= fill_n;
         state_q   <= state_n;
         dout_q    <= dout_n;
      end
   end

   always_comb begin
      pattern_n = pattern_q;
      mask_n    = mask_q;
      hist_n    = hist_q;
      fill_n    = fill_q;
      dout_n    = 1'b0;
      hit       = 1'b0;
      hist_sh   = {hist_q[PAT_LEN-2:0], bus.din};
      fill_sh   = (fill_q == FULL) ? FULL : fill_q + FW'(1);

      // A load restarts history; any bit offered alongside it is discarded.
      if (bus.pat_load) begin
         pattern_n = bus.pat_in;
         mask_n    = bus.mask_in;
         hist_n    = '0;
         fill_n    = '0;
      end else if (bus.en && bus.din_valid) begin
         hist_n = hist_sh;
         fill_n = fill_sh;
         if ((fill_sh == FULL) && (((hist_sh ^ pattern_q) & ~mask_q) == '0)) begin
            hit    = 1'b1;
            dout_n = 1'b1;
            if (!bus.overlap) begin
               fill_n = '0;
            end
         end
      end

      state_n = (fill_n == FULL) ? ARMED : FILL;
   end

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk     (clk),
      .clr     (clr),
      .inc     (hit),
      .clr_cnt (bus.cnt_clr),
      .q       (bus.match_cnt),
      .sat     (bus.cnt_sat)
   );

   assign bus.dout  = dout_q;
   assign bus.armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default 5-bit 10001 detector plus a 2-bit/2-bit-counter instance for saturation.
module tb_seq_detect_param;

   logic clk = 1'b0;
   logic clr;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_detect_param_if #(.PAT_LEN(5), .CNT_W(8)) ia ();
   seq_detect_param_if #(.PAT_LEN(2), .CNT_W(2)) ib ();

   seq_detect_param #(.PAT_LEN(5), .PAT_DEFAULT(5'b10001), .CNT_W(8)) dut_a (
      .clk (clk),
      .clr (clr),
      .bus (ia)
   );

   seq_detect_param #(.PAT_LEN(2), .PAT_DEFAULT(2'b11), .CNT_W(2)) dut_b (
      .clk (clk),
      .clr (clr),
      .bus (ib)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic a_drive(input logic e, input logic v, input logic d);
      ia.en        = e;
      ia.din_valid = v;
      ia.din       = d;
      tick();
      ia.din_valid = 1'b0;
   endtask

   task automatic b_drive(input logic d);
      ib.en        = 1'b1;
      ib.din_valid = 1'b1;
      ib.din       = d;
      tick();
      ib.din_valid = 1'b0;
   endtask

   task automatic a_chk(input string tag, input logic d, input int cnt, input logic arm);
      chk({tag, "_dout"},  32'(ia.dout),      32'(d));
      chk({tag, "_cnt"},   32'(ia.match_cnt), 32'(cnt));
      chk({tag, "_armed"}, 32'(ia.armed),     32'(arm));
   endtask

   task automatic b_chk(input string tag, input logic d, input int cnt, input logic sat);
      chk({tag, "_dout"}, 32'(ib.dout),      32'(d));
      chk({tag, "_cnt"},  32'(ib.match_cnt), 32'(cnt));
      chk({tag, "_sat"},  32'(ib.cnt_sat),   32'(sat));
   endtask

   initial begin
      clr = 1'b1;
      ia.en = 1'b0; ia.din_valid = 1'b0; ia.din = 1'b0; ia.overlap = 1'b0;
      ia.pat_load = 1'b0; ia.pat_in = '0; ia.mask_in = '0; ia.cnt_clr = 1'b0;
      ib.en = 1'b0; ib.din_valid = 1'b0; ib.din = 1'b0; ib.overlap = 1'b0;
      ib.pat_load = 1'b0; ib.pat_in = '0; ib.mask_in = '0; ib.cnt_clr = 1'b0;
      tick();
      tick();
      clr = 1'b0;
      a_chk("rst", 1'b0, 0, 1'b0);
      chk("rst_sat", 32'(ia.cnt_sat), 32'd0);

      // Overlapping matches on 1,0,0,0,1,0,0,0,1
      ia.overlap = 1'b1;
      a_drive(1, 1, 1); a_drive(1, 1, 0); a_drive(1, 1, 0); a_drive(1, 1, 0);
      a_chk("t1_b4", 1'b0, 0, 1'b0);
      a_drive(1, 1, 1);
      a_chk("t1_b5", 1'b1, 1, 1'b1);
      a_drive(1, 1, 0);
      a_chk("t1_b6", 1'b0, 1, 1'b1);
      a_drive(1, 1, 0); a_drive(1, 1, 0);
      a_drive(1, 1, 1);
      a_chk("t1_b9", 1'b1, 2, 1'b1);
      tick();
      a_chk("t1_idle", 1'b0, 2, 1'b1);

      ia.cnt_clr = 1'b1;
      tick();
      ia.cnt_clr = 1'b0;
      a_chk("cntclr", 1'b0, 0, 1'b1);

      // Non-overlapping: second 10001 shares its first bit, so no second hit
      clr_pulse();
      ia.overlap = 1'b0;
      a_drive(1, 1, 1); a_drive(1, 1, 0); a_drive(1, 1, 0); a_drive(1, 1, 0);
      a_drive(1, 1, 1);
      a_chk("t2_b5", 1'b1, 1, 1'b0);
      a_drive(1, 1, 0); a_drive(1, 1, 0); a_drive(1, 1, 0);
      a_drive(1, 1, 1);
      a_chk("t2_b9", 1'b0, 1, 1'b0);

      // Masked pattern 1xxx1; the bit offered with the load must be dropped
      clr_pulse();
      ia.overlap   = 1'b1;
      ia.pat_load  = 1'b1;
      ia.pat_in    = 5'b10001;
      ia.mask_in   = 5'b01110;
      ia.en        = 1'b1;
      ia.din_valid = 1'b1;
      ia.din       = 1'b1;
      tick();
      ia.pat_load  = 1'b0;
      ia.din_valid = 1'b0;
      a_chk("t3_load", 1'b0, 0, 1'b0);
      a_drive(1, 1, 1); a_drive(1, 1, 1); a_drive(1, 1, 1); a_drive(1, 1, 1);
      a_chk("t3_b4", 1'b0, 0, 1'b0);
      a_drive(1, 1, 1);
      a_chk("t3_b5", 1'b1, 1, 1'b1);

      // Bubbles between bits of a partial match
      ia.pat_load = 1'b1;
      ia.pat_in   = 5'b10001;
      ia.mask_in  = 5'b00000;
      tick();
      ia.pat_load = 1'b0;
      a_chk("t4_load", 1'b0, 1, 1'b0);
      a_drive(1, 1, 1); a_drive(1, 1, 0);
      a_drive(1, 0, 1);
      a_chk("t4_gap1", 1'b0, 1, 1'b0);
      a_drive(0, 1, 1);
      a_chk("t4_gap2", 1'b0, 1, 1'b0);
      a_drive(0, 0, 0);
      a_chk("t4_gap3", 1'b0, 1, 1'b0);
      a_drive(1, 1, 0); a_drive(1, 1, 0);
      a_chk("t4_b4", 1'b0, 1, 1'b0);
      a_drive(1, 1, 1);
      a_chk("t4_b5", 1'b1, 2, 1'b1);

      // clr in the middle of a partial match
      clr_pulse();
      a_drive(1, 1, 1); a_drive(1, 1, 0); a_drive(1, 1, 0); a_drive(1, 1, 0);
      clr_pulse();
      a_chk("t5_clr", 1'b0, 0, 1'b0);
      chk("t5_clr_sat", 32'(ia.cnt_sat), 32'd0);
      a_drive(1, 1, 1);
      a_chk("t5_b1", 1'b0, 0, 1'b0);
      a_drive(1, 1, 0); a_drive(1, 1, 0); a_drive(1, 1, 0);
      a_chk("t5_b4", 1'b0, 0, 1'b0);
      a_drive(1, 1, 1);
      a_chk("t5_b5", 1'b1, 1, 1'b1);

      // 2-bit pattern 11, 2-bit counter: saturation and clear-with-hit
      clr_pulse();
      ib.overlap = 1'b1;
      b_drive(1);
      b_chk("b_b1", 1'b0, 0, 1'b0);
      b_drive(1);
      b_chk("b_b2", 1'b1, 1, 1'b0);
      chk("b_b2_armed", 32'(ib.armed), 32'd1);
      b_drive(1);
      b_chk("b_b3", 1'b1, 2, 1'b0);
      b_drive(1);
      b_chk("b_b4", 1'b1, 3, 1'b1);
      b_drive(1);
      b_chk("b_b5", 1'b1, 3, 1'b1);
      b_drive(1);
      b_chk("b_b6", 1'b1, 3, 1'b1);
      ib.cnt_clr = 1'b1;
      b_drive(1);
      b_chk("b_clr_hit", 1'b1, 1, 1'b0);
      tick();
      ib.cnt_clr = 1'b0;
      b_chk("b_clr_only", 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
